// File: rtl/snn_pkg.sv
// Shared types for the amplitude scanner: FSM states and spike events.
// Event fields are sized for the largest supported configuration.
package snn_pkg;

   localparam int NEURON_NO_DEF = 256;
   localparam int ADDR_WID      = $clog2(NEURON_NO_DEF);
   localparam int EVT_TS_WID    = 12;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN
   } scan_state_t;

   typedef struct packed {
      logic [ADDR_WID-1:0]   addr;
      logic [EVT_TS_WID-1:0] ts;
   } spike_evt_t;

endpackage

// File: rtl/ampl_scanner_if.sv
// Amplitude-store read port plus spike event valid/ready output.
// master = scanner side, slave = store/router side.
interface ampl_scanner_if #(
   parameter int AW = 8,
   parameter int DW = 12,
   parameter int TW = 12
);

   logic          re;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] ampl_a;
   logic [DW-1:0] ampl_b;
   logic          sp_valid;
   logic          sp_ready;
   logic [AW-1:0] sp_addr;
   logic [TW-1:0] sp_ts;

   modport master (
      output re, rd_addr,
      input  ampl_a, ampl_b,
      output sp_valid, sp_addr, sp_ts,
      input  sp_ready
   );

   modport slave (
      input  re, rd_addr,
      output ampl_a, ampl_b,
      input  sp_valid, sp_addr, sp_ts,
      output sp_ready
   );

endinterface

// File: rtl/spike_fifo2.sv
// Two-entry spike event FIFO; head entry is always visible on dout.
// Push and pop may coincide at any occupancy.
module spike_fifo2
   import snn_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  spike_evt_t din,
   output spike_evt_t dout,
   output logic [1:0] occ,
   output logic       full,
   output logic       empty
);

   spike_evt_t mem [2];
   logic       wp;
   logic       rp;
   logic [1:0] occ_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wp    <= 1'b0;
         rp    <= 1'b0;
         occ_q <= 2'd0;
         for (int i = 0; i < 2; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wp] <= din;
            wp      <= ~wp;
         end
         if (pop) rp <= ~rp;
         occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
      end
   end

   assign dout  = mem[rp];
   assign occ   = occ_q;
   assign full  = (occ_q == 2'd2);
   assign empty = (occ_q == 2'd0);

endmodule

// File: rtl/ampl_scanner.sv
// Per-timestep sweep of the amplitude RAMs; emits a spike event for
// every neuron whose a-b potential reaches threshold.
module ampl_scanner
   import snn_pkg::*;
#(
   parameter int NEURON_NO = 256,
   parameter int AMPL_WID  = 12,
   parameter int TS_WID    = 12
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ts_tick,
   input  logic [AMPL_WID-1:0] threshold,
   ampl_scanner_if.master      bus,
   output logic [TS_WID-1:0]   ts_cnt,
   output logic                busy,
   output logic                done,
   output logic                overrun
);

   localparam int AW = $clog2(NEURON_NO);
   localparam logic [AW-1:0] LAST = AW'(NEURON_NO - 1);

   scan_state_t state, state_nxt;

   logic [AW-1:0] nxt_addr;
   logic [AW-1:0] last_addr;
   logic [AW-1:0] eval_addr;
   logic          inflight;
   logic          issue;
   logic          pop;
   logic          push;
   logic          fire;
   logic          drained;
   logic [2:0]    credit;
   logic [1:0]    occ;
   logic          full;
   logic          empty;
   logic signed [AMPL_WID:0] v;
   spike_evt_t    evt_in;
   spike_evt_t    evt_out;

   assign pop    = bus.sp_valid & bus.sp_ready;
   assign credit = {1'b0, occ} + {2'b0, inflight};
   // Credit counts every outstanding read as a future event
   assign issue  = (state == SCAN) && (credit < 3'd2 + {2'b0, pop});

   assign v    = $signed({1'b0, bus.ampl_a}) - $signed({1'b0, bus.ampl_b});
   assign fire = (v >= $signed({1'b0, threshold}));
   assign push = inflight & fire;

   assign evt_in.addr = ADDR_WID'(eval_addr);
   assign evt_in.ts   = EVT_TS_WID'(ts_cnt);

   assign drained = !inflight && empty;

   spike_fifo2 u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (evt_in),
      .dout  (evt_out),
      .occ   (occ),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (ts_tick) state_nxt = SCAN;
         SCAN:    if (issue && nxt_addr == LAST) state_nxt = DRAIN;
         DRAIN:   if (drained) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy         = (state != IDLE);
      done         = (state == DRAIN) && drained;
      bus.re       = issue;
      bus.rd_addr  = issue ? nxt_addr : last_addr;
      bus.sp_valid = !empty;
      bus.sp_addr  = AW'(evt_out.addr);
      bus.sp_ts    = TS_WID'(evt_out.ts);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         nxt_addr  <= '0;
         last_addr <= '0;
         eval_addr <= '0;
         inflight  <= 1'b0;
         ts_cnt    <= '0;
         overrun   <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            last_addr <= nxt_addr;
            eval_addr <= nxt_addr;
            nxt_addr  <= nxt_addr + AW'(1);
         end else if (state == IDLE && ts_tick) begin
            nxt_addr <= '0;
         end
         if (ts_tick) begin
            if (state == IDLE) ts_cnt  <= ts_cnt + TS_WID'(1);
            else               overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ampl_scanner.sv
// Scoreboard bench for ampl_scanner with 8 neurons and a 2-bit
// timestep so the counter wraps within a few sweeps.
module tb_ampl_scanner;

   localparam int NN = 8;
   localparam int AWD = 12;
   localparam int TW = 2;

   typedef struct {
      int addr;
      int ts;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic ts_tick;
   logic [AWD-1:0] threshold;
   logic [TW-1:0] ts_cnt;
   logic busy, done, overrun;

   ampl_scanner_if #(.AW(3), .DW(AWD), .TW(TW)) bus ();

   ampl_scanner #(
      .NEURON_NO (NN),
      .AMPL_WID  (AWD),
      .TS_WID    (TW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ts_tick   (ts_tick),
      .threshold (threshold),
      .bus       (bus),
      .ts_cnt    (ts_cnt),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   logic [AWD-1:0] la [NN];
   logic [AWD-1:0] lb [NN];

   always @(posedge clk) begin
      bus.ampl_a <= bus.re ? la[bus.rd_addr] : '0;
      bus.ampl_b <= bus.re ? lb[bus.rd_addr] : '0;
   end

   int n_chk = 0;
   int n_err = 0;
   exp_t q[$];
   int ts_model = 0;
   int cyc = 0;
   int re_cnt, done_cnt, run, max_run;
   int last_re_cyc, done_cyc;
   logic prev_stall = 1'b0;
   logic prev_done = 1'b0;
   logic [2:0] prev_addr;
   logic [TW-1:0] prev_ts;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         if (bus.re) begin
            re_cnt++;
            run++;
            last_re_cyc = cyc;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (prev_done) check("busy_fall", {31'd0, busy}, 0);
         if (dut.push && dut.full) check("push_full", 1, 0);
         if (prev_stall)
            check("hold", {26'd0, bus.sp_valid, bus.sp_addr, bus.sp_ts},
                  {26'd0, 1'b1, prev_addr, prev_ts});
         if (bus.sp_valid && bus.sp_ready) begin
            if (q.size() == 0) begin
               check("unexpected_evt", {29'd0, bus.sp_addr}, 32'hffff);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("sp_addr", {29'd0, bus.sp_addr}, e.addr);
               check("sp_ts", {30'd0, bus.sp_ts}, e.ts);
            end
         end
      end
      prev_done  = done && !reset;
      prev_stall = bus.sp_valid && !bus.sp_ready && !reset;
      prev_addr  = bus.sp_addr;
      prev_ts    = bus.sp_ts;
   end

   task automatic tick;
      ts_tick = 1'b1;
      @(posedge clk); #1;
      ts_tick = 1'b0;
   endtask

   task automatic load_expected;
      ts_model = (ts_model + 1) % 4;
      for (int a = 0; a < NN; a++) begin
         int v;
         v = int'(la[a]) - int'(lb[a]);
         if (v >= int'(threshold)) q.push_back('{a, ts_model});
      end
   endtask

   task automatic run_sweep(input bit stall, input bit ovr,
                            input bit chk_gap);
      int snap;
      re_cnt = 0; done_cnt = 0; run = 0; max_run = 0;
      load_expected();
      tick();
      check("first_re", {27'd0, bus.re, busy, bus.rd_addr}, {27'd0, 2'b11, 3'd0});
      for (int i = 0; i < 300 && done_cnt == 0; i++) begin
         if (stall && i == 13)
            check("re_stall", re_cnt - snap, 0);
         if (i == 8) snap = re_cnt;
         bus.sp_ready = !(stall && i >= 3 && i < 13);
         ts_tick = ovr && (i == 5);
         @(posedge clk); #1;
      end
      ts_tick = 1'b0;
      bus.sp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("done_cnt", done_cnt, 1);
      check("re_cnt", re_cnt, NN);
      check("q_empty", q.size(), 0);
      check("ts_cnt", {30'd0, ts_cnt}, ts_model);
      if (!stall) check("re_run", max_run, NN);
      if (chk_gap) check("done_gap", done_cyc - last_re_cyc, 2);
   endtask

   initial begin
      reset = 1'b1;
      ts_tick = 1'b0;
      threshold = 12'd5;
      bus.sp_ready = 1'b1;
      for (int a = 0; a < NN; a++) begin
         la[a] = 12'd10;
         lb[a] = 12'd2;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_out",
               {21'd0, bus.re, bus.rd_addr, bus.sp_valid, bus.sp_addr,
                bus.sp_ts, busy, done, overrun},
               0);
         check("idle_ts", {30'd0, ts_cnt}, 0);
      end
      @(posedge clk); #1;

      run_sweep(1'b0, 1'b0, 1'b0);

      for (int a = 0; a < NN; a++) begin
         la[a] = 12'd0;
         lb[a] = 12'd0;
      end
      la[3] = 12'd9;  lb[3] = 12'd4;
      la[4] = 12'd9;  lb[4] = 12'd5;
      la[5] = 12'd0;  lb[5] = 12'd7;
      check("q_pre_thr", q.size(), 0);
      run_sweep(1'b0, 1'b0, 1'b1);

      for (int a = 0; a < NN; a++) begin
         la[a] = 12'd100 + 12'(a);
         lb[a] = 12'd1;
      end
      check("ovr_pre", {31'd0, overrun}, 0);
      run_sweep(1'b1, 1'b1, 1'b0);
      check("ovr_post", {31'd0, overrun}, 1);

      threshold = 12'd0;
      run_sweep(1'b0, 1'b0, 1'b0);
      check("ts_wrap", {30'd0, ts_cnt}, 0);

      done_cnt = 0;
      load_expected();
      tick();
      for (int i = 0; i < 50; i++) begin
         if (bus.re && bus.rd_addr == 3'd4) break;
         @(posedge clk); #1;
      end
      check("rst_at4", {28'd0, bus.re, bus.rd_addr}, {28'd0, 1'b1, 3'd4});
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      q.delete();
      ts_model = 0;
      check("rst_state",
            {28'd0, bus.sp_valid, bus.re, busy, done}, 0);
      check("rst_ts", {30'd0, ts_cnt}, 0);
      repeat (5) @(posedge clk);
      #1;
      check("rst_nodone", done_cnt, 0);

      threshold = 12'd5;
      for (int a = 0; a < NN; a++) begin
         la[a] = 12'd10;
         lb[a] = 12'd2;
      end
      run_sweep(1'b0, 1'b0, 1'b0);
      check("restart_ts", {30'd0, ts_cnt}, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
